// File: rtl/median3x3_word_engine.sv
`default_nettype none
// ============================================================================
// Module  : median3x3_word_engine
// Brief   : Exact 3x3 median over 8-pixel row words; output runs one word behind
//           input. Optional macro MEDIAN_BYPASS_EN adds a per-word row1 bypass.
// Revision: 1.0
// ============================================================================
module median3x3_word_engine #(
  parameter int PW  = 8,
  parameter int PPW = 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PW*PPW-1:0] row0,
  input  logic [PW*PPW-1:0] row1,
  input  logic [PW*PPW-1:0] row2,
  input  logic              line_start,
  input  logic              line_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PW*PPW-1:0] result,
  output logic              out_last
`ifdef MEDIAN_BYPASS_EN
  ,
  input  logic              bypass
`endif
);
  localparam int DW = PW * PPW;
  localparam int NC = PPW + 2;

  typedef logic [PW-1:0] pix_t;
  typedef logic [2:0][PW-1:0] col_t;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  function automatic col_t col_of(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                                  input logic [DW-1:0] r2, input int k);
    col_t c;
    c[0] = r0[k*PW +: PW];
    c[1] = r1[k*PW +: PW];
    c[2] = r2[k*PW +: PW];
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  col_t            hleft_q, hleft_d;
  logic            issue, issue_last;
  col_t            issue_right;
  logic            adv;
  col_t [NC-1:0]   win;

  logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [NC-1:0][PW-1:0] s1_lo_q, s1_lo_d, s1_mid_q, s1_mid_d, s1_hi_q, s1_hi_d;
  logic                  s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [PPW-1:0][PW-1:0] s2_maxlo_q, s2_maxlo_d, s2_medmid_q, s2_medmid_d;
  logic [PPW-1:0][PW-1:0] s2_minhi_q, s2_minhi_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]         result_q, result_d;
`ifdef MEDIAN_BYPASS_EN
  logic                  hbyp_q, hbyp_d, s1_byp_q, s1_byp_d, s2_byp_q, s2_byp_d;
  logic [DW-1:0]         s1_ctr_q, s1_ctr_d, s2_ctr_q, s2_ctr_d;
`endif

  assign adv       = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign result    = result_q;

  always_comb begin
    state_d     = state_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    hleft_d     = hleft_q;
    in_ready    = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    issue_right = col_of(h0_q, h1_q, h2_q, PPW-1);
`ifdef MEDIAN_BYPASS_EN
    hbyp_d      = hbyp_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = adv;
        if (in_valid && adv) begin
          h0_d    = row0;
          h1_d    = row1;
          h2_d    = row2;
          hleft_d = col_of(row0, row1, row2, 0);
`ifdef MEDIAN_BYPASS_EN
          hbyp_d  = bypass;
`endif
          state_d = line_end ? FLUSH : HOLD;
        end
      end
      HOLD: begin
        // A new line_start while a word is held means line_end was lost: flush first.
        if (in_valid && line_start) begin
          state_d = FLUSH;
        end else begin
          in_ready = adv;
          if (in_valid && adv) begin
            issue       = 1'b1;
            issue_right = col_of(row0, row1, row2, 0);
            hleft_d     = col_of(h0_q, h1_q, h2_q, PPW-1);
            h0_d        = row0;
            h1_d        = row1;
            h2_d        = row2;
`ifdef MEDIAN_BYPASS_EN
            hbyp_d      = bypass;
`endif
            state_d     = line_end ? FLUSH : HOLD;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          issue      = 1'b1;
          issue_last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (prst) in_ready = 1'b0;
  end

  always_comb begin
    win[0]    = hleft_q;
    for (int k = 0; k < PPW; k++) win[k+1] = col_of(h0_q, h1_q, h2_q, k);
    win[NC-1] = issue_right;

    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_lo_d     = s1_lo_q;
    s1_mid_d    = s1_mid_q;
    s1_hi_d     = s1_hi_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_maxlo_d  = s2_maxlo_q;
    s2_medmid_d = s2_medmid_q;
    s2_minhi_d  = s2_minhi_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    result_d    = result_q;
`ifdef MEDIAN_BYPASS_EN
    s1_byp_d    = s1_byp_q;
    s1_ctr_d    = s1_ctr_q;
    s2_byp_d    = s2_byp_q;
    s2_ctr_d    = s2_ctr_q;
`endif
    if (adv) begin
      s1_valid_d = issue;
      s1_last_d  = issue_last;
      for (int c = 0; c < NC; c++) begin
        s1_lo_d[c]  = min2(min2(win[c][0], win[c][1]), win[c][2]);
        s1_mid_d[c] = med3(win[c][0], win[c][1], win[c][2]);
        s1_hi_d[c]  = max2(max2(win[c][0], win[c][1]), win[c][2]);
      end
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      for (int k = 0; k < PPW; k++) begin
        s2_maxlo_d[k]  = max2(max2(s1_lo_q[k], s1_lo_q[k+1]), s1_lo_q[k+2]);
        s2_medmid_d[k] = med3(s1_mid_q[k], s1_mid_q[k+1], s1_mid_q[k+2]);
        s2_minhi_d[k]  = min2(min2(s1_hi_q[k], s1_hi_q[k+1]), s1_hi_q[k+2]);
      end
      out_valid_d = s2_valid_q;
      out_last_d  = s2_last_q;
      for (int k = 0; k < PPW; k++)
        result_d[k*PW +: PW] = med3(s2_maxlo_q[k], s2_medmid_q[k], s2_minhi_q[k]);
`ifdef MEDIAN_BYPASS_EN
      s1_byp_d = hbyp_q;
      s1_ctr_d = h1_q;
      s2_byp_d = s1_byp_q;
      s2_ctr_d = s1_ctr_q;
      if (s2_byp_q) result_d = s2_ctr_q;
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      h0_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      hleft_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_lo_q     <= '0;
      s1_mid_q    <= '0;
      s1_hi_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_maxlo_q  <= '0;
      s2_medmid_q <= '0;
      s2_minhi_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      result_q    <= '0;
`ifdef MEDIAN_BYPASS_EN
      hbyp_q      <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_ctr_q    <= '0;
      s2_byp_q    <= 1'b0;
      s2_ctr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      hleft_q     <= hleft_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_lo_q     <= s1_lo_d;
      s1_mid_q    <= s1_mid_d;
      s1_hi_q     <= s1_hi_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_maxlo_q  <= s2_maxlo_d;
      s2_medmid_q <= s2_medmid_d;
      s2_minhi_q  <= s2_minhi_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      result_q    <= result_d;
`ifdef MEDIAN_BYPASS_EN
      hbyp_q      <= hbyp_d;
      s1_byp_q    <= s1_byp_d;
      s1_ctr_q    <= s1_ctr_d;
      s2_byp_q    <= s2_byp_d;
      s2_ctr_q    <= s2_ctr_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_median3x3_word_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_median3x3_word_engine
// Brief   : Directed self-checking bench for median3x3_word_engine.
// Revision: 1.0
// ============================================================================
module tb_median3x3_word_engine;
  logic        pclk, prst, in_valid, in_ready, line_start, line_end;
  logic        out_valid, out_ready, out_last;
  logic [63:0] row0, row1, row2, result;
`ifdef MEDIAN_BYPASS_EN
  logic        bypass;
`endif

  int checks   = 0;
  int failures = 0;
  logic [63:0] res_q[$];
  logic        last_q[$];

  median3x3_word_engine dut (
    .pclk(pclk), .prst(prst), .in_valid(in_valid), .in_ready(in_ready),
    .row0(row0), .row1(row1), .row2(row2),
    .line_start(line_start), .line_end(line_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_last(out_last)
`ifdef MEDIAN_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk)
    if (!prst && out_valid && out_ready) begin
      res_q.push_back(result);
      last_q.push_back(out_last);
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic ls, input logic le);
    int n = 0;
    row0 = a; row1 = b; row2 = c; line_start = ls; line_end = le; in_valid = 1'b1;
    @(negedge pclk);
    while (!in_ready && n < 50) begin @(negedge pclk); n++; end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge pclk); #1;
    in_valid = 1'b0; line_start = 1'b0; line_end = 1'b0;
  endtask

  task automatic sendu(input logic [63:0] w, input logic ls, input logic le);
    send(w, w, w, ls, le);
  endtask

  task automatic wait_n(input string tag, input int n);
    int t = 0;
    while (res_q.size() < n && t < 200) begin @(posedge pclk); t++; end
    repeat (4) @(posedge pclk);
    #1;
    check({tag, "_count"}, 64'(res_q.size()), 64'(n));
  endtask

  task automatic expect_res(input string tag, input logic [63:0] w, input logic last);
    logic [63:0] g = 64'hx;
    logic        l = 1'bx;
    if (res_q.size() > 0) begin g = res_q.pop_front(); l = last_q.pop_front(); end
    check(tag, g, w);
    check({tag, "_last"}, 64'(l), 64'(last));
  endtask

  initial begin
    pclk = 1'b0; prst = 1'b1; in_valid = 1'b0; line_start = 1'b0; line_end = 1'b0;
    row0 = '0; row1 = '0; row2 = '0; out_ready = 1'b1;
`ifdef MEDIAN_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(posedge pclk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    prst = 1'b0;

    // Uniform field
    sendu(64'h5A5A5A5A5A5A5A5A, 1'b1, 1'b0);
    sendu(64'h5A5A5A5A5A5A5A5A, 1'b0, 1'b0);
    sendu(64'h5A5A5A5A5A5A5A5A, 1'b0, 1'b1);
    wait_n("uni", 3);
    expect_res("uni0", 64'h5A5A5A5A5A5A5A5A, 1'b0);
    expect_res("uni1", 64'h5A5A5A5A5A5A5A5A, 1'b0);
    expect_res("uni2", 64'h5A5A5A5A5A5A5A5A, 1'b1);

    // Impulse with timing
    send(64'd0, 64'h00000000FF000000, 64'd0, 1'b1, 1'b1);
    check("imp_flush_rdy", 64'(in_ready), 64'd0);
    repeat (2) begin @(posedge pclk); #1; check("imp_early", 64'(out_valid), 64'd0); end
    @(posedge pclk); #1;
    check("imp_valid", 64'(out_valid), 64'd1);
    wait_n("imp", 1);
    expect_res("imp", 64'd0, 1'b1);

    // Edge replicate ramp
    sendu(64'h0706050403020100, 1'b1, 1'b1);
    wait_n("ramp", 1);
    expect_res("ramp", 64'h0706050403020100, 1'b1);

    // Horizontal neighbours across a word boundary
    sendu(64'hC800080303050109, 1'b1, 1'b0);
    sendu(64'h04FF020264070732, 1'b0, 1'b1);
    wait_n("nbr", 2);
    expect_res("nbrA", 64'h3208030303030509, 1'b0);
    expect_res("nbrB", 64'h0404020207070732, 1'b1);

    // Vertical sort: columns {FF,00,80}
    send({8{8'hFF}}, 64'd0, {8{8'h80}}, 1'b1, 1'b1);
    wait_n("vert", 1);
    expect_res("vert", {8{8'h80}}, 1'b1);

    // Backpressure
    fork
      begin
        for (int i = 1; i <= 6; i++)
          sendu({8{8'(i * 17)}}, i == 1, i == 6);
      end
      begin
        int t = 0;
        while (!out_valid && t < 100) begin @(posedge pclk); #1; t++; end
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge pclk); #1;
          check("bp_hold", result, {8{8'h11}});
          check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_n("bp", 6);
    for (int i = 1; i <= 6; i++)
      expect_res("bp", {8{8'(i * 17)}}, i == 6);

    // Missing line_end recovery
    sendu(64'h1050505050505050, 1'b1, 1'b0);
    row0 = {8{8'h20}}; row1 = {8{8'h20}}; row2 = {8{8'h20}};
    line_start = 1'b1; line_end = 1'b1; in_valid = 1'b1;
    @(negedge pclk);
    check("rec_rdy", 64'(in_ready), 64'd0);
    @(posedge pclk); #1;
    sendu({8{8'h20}}, 1'b1, 1'b1);
    wait_n("rec", 2);
    expect_res("recA", 64'h1050505050505050, 1'b1);
    expect_res("recB", {8{8'h20}}, 1'b1);

    // Reset with words in flight
    sendu({8{8'h33}}, 1'b1, 1'b0);
    sendu({8{8'h44}}, 1'b0, 1'b0);
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    check("rstm_out_valid", 64'(out_valid), 64'd0);
    check("rstm_in_ready", 64'(in_ready), 64'd0);
    check("rstm_result", result, 64'd0);
    prst = 1'b0;
    res_q.delete();
    last_q.delete();
    send(64'h0706050403020100, 64'd0, {8{8'hFF}}, 1'b1, 1'b1);
    wait_n("post", 1);
    expect_res("post", 64'h0706050403020100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
